// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: widths, control bundle layout,
// architectural register numbers and ALUOp encodings used by ID/EX and EX.
package mips_pipe_pkg;

   localparam int DATA_W = 64;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 16;

   // Control bundle layout, MSB first:
   // RegWrite | MemRead | MemWrite | MemToReg | ALUSrc | RegDst | JmpandLink | ALUOp[3:0]
   localparam int CTRL_W         = 11;
   localparam int CTRL_REG_WRITE = 10;
   localparam int CTRL_MEM_READ  = 9;
   localparam int CTRL_MEM_WRITE = 8;
   localparam int CTRL_MEM2REG   = 7;
   localparam int CTRL_ALU_SRC   = 6;
   localparam int CTRL_REG_DST   = 5;
   localparam int CTRL_JAL       = 4;
   localparam int CTRL_ALUOP_MSB = 3;
   localparam int CTRL_ALUOP_LSB = 0;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_XOR = 4'h4;
   localparam logic [3:0] ALU_NOR = 4'h5;
   localparam logic [3:0] ALU_SLT = 4'h6;
   localparam logic [3:0] ALU_SLL = 4'h7;
   localparam logic [3:0] ALU_SRL = 4'h8;
   localparam logic [3:0] ALU_SRA = 4'h9;
   localparam logic [3:0] ALU_LUI = 4'hA;

   // Zero-extends the low word; the datapath only ever carries 32-bit values.
   function automatic logic [DATA_W-1:0] low_word(input logic [DATA_W-1:0] v);
      return {{(DATA_W-32){1'b0}}, v[31:0]};
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, writeback-side and EX-side signals of the ID/EX stage.
// slave: the stage itself; master: the surrounding pipeline driving it.
interface id_ex_stage_if;
   import mips_pipe_pkg::*;

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_read_data1;
   logic [DATA_W-1:0] id_read_data2;
   logic [15:0]       id_imm16;
   logic [CTRL_W-1:0] id_ctrl;

   logic              wb_reg_write;
   logic              wb_jal;
   logic [REG_AW-1:0] wb_dst_reg;
   logic [DATA_W-1:0] wb_data;

   logic              ex_flush;
   logic              ex_stall;

   logic              ex_valid;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_dst;
   logic [DATA_W-1:0] ex_op_a;
   logic [DATA_W-1:0] ex_op_b;
   logic [DATA_W-1:0] ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              stall_if_id;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_read_data1, id_read_data2,
             id_imm16, id_ctrl, wb_reg_write, wb_jal, wb_dst_reg, wb_data,
             ex_flush, ex_stall,
      input  ex_valid, ex_rs, ex_rt, ex_dst, ex_op_a, ex_op_b, ex_imm,
             ex_ctrl, stall_if_id, bubble_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_read_data1, id_read_data2,
             id_imm16, id_ctrl, wb_reg_write, wb_jal, wb_dst_reg, wb_data,
             ex_flush, ex_stall,
      output ex_valid, ex_rs, ex_rt, ex_dst, ex_op_a, ex_op_b, ex_imm,
             ex_ctrl, stall_if_id, bubble_cnt
   );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// hazard_detect_unit: combinational load-use detection between the load
// sitting in EX and the instruction in decode.
module hazard_detect_unit
   import mips_pipe_pkg::*;
(
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              ex_flush,
   input  logic              ex_stall,
   output logic              hz,
   output logic              stall_if_id
);

   // A flush kills the consumer anyway, and a downstream stall already holds
   // the front end, so neither needs the load-use stall on top.
   always_comb begin
      hz = ex_valid && ex_mem_read && (ex_dst != REG_ZERO) && id_valid &&
           ((ex_dst == id_rs) || (ex_dst == id_rt));
      stall_if_id = hz && !ex_flush && !ex_stall;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// bubble counter. Optional macro ID_EX_WB_BYPASS_EN enables write-through of
// the writeback value into the captured operands.
module id_ex_stage
   import mips_pipe_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   logic              valid_q, valid_d;
   logic [REG_AW-1:0] rs_q, rs_d;
   logic [REG_AW-1:0] rt_q, rt_d;
   logic [REG_AW-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              hz;
   logic              stall_if_id;
   logic [REG_AW-1:0] id_dst;
   logic [DATA_W-1:0] id_imm_ext;
   logic [DATA_W-1:0] op_a_cap;
   logic [DATA_W-1:0] op_b_cap;

   hazard_detect_unit u_hazard (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
      .ex_dst      (dst_q),
      .id_valid    (bus.id_valid),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .ex_flush    (bus.ex_flush),
      .ex_stall    (bus.ex_stall),
      .hz          (hz),
      .stall_if_id (stall_if_id)
   );

   // Destination select and immediate extension for the decode slot.
   always_comb begin
      if (bus.id_ctrl[CTRL_JAL]) begin
         id_dst = REG_RA;
      end else if (bus.id_ctrl[CTRL_REG_DST]) begin
         id_dst = bus.id_rd;
      end else begin
         id_dst = bus.id_rt;
      end
      id_imm_ext = {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16};
   end

`ifdef ID_EX_WB_BYPASS_EN
   logic [REG_AW-1:0] wb_eff_reg;
   logic              wb_hit_ok;
   logic              unused_ok;

   // Write-through: the register file write and the read happen in the same
   // cycle, so forward the writeback value straight into the capture.
   always_comb begin
      wb_eff_reg = bus.wb_jal ? REG_RA : bus.wb_dst_reg;
      wb_hit_ok  = bus.wb_reg_write && (wb_eff_reg != REG_ZERO);
      op_a_cap   = (wb_hit_ok && (wb_eff_reg == bus.id_rs)) ?
                   low_word(bus.wb_data) : low_word(bus.id_read_data1);
      op_b_cap   = (wb_hit_ok && (wb_eff_reg == bus.id_rt)) ?
                   low_word(bus.wb_data) : low_word(bus.id_read_data2);
   end

   assign unused_ok = ^{bus.id_read_data1[DATA_W-1:32],
                        bus.id_read_data2[DATA_W-1:32],
                        bus.wb_data[DATA_W-1:32]};
`else
   logic unused_ok;

   // Operands come from the register file only; upper word is always zero.
   always_comb begin
      op_a_cap = low_word(bus.id_read_data1);
      op_b_cap = low_word(bus.id_read_data2);
   end

   assign unused_ok = ^{bus.id_read_data1[DATA_W-1:32],
                        bus.id_read_data2[DATA_W-1:32],
                        bus.wb_reg_write, bus.wb_jal, bus.wb_dst_reg,
                        bus.wb_data};
`endif

   // Next-state of the EX registers: flush, then stall, then bubble, then capture.
   always_comb begin
      valid_d = valid_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      dst_d   = dst_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      imm_d   = imm_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (bus.ex_flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (bus.ex_stall) begin
         valid_d = valid_q;
      end else if (hz) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         valid_d = bus.id_valid;
         rs_d    = bus.id_rs;
         rt_d    = bus.id_rt;
         dst_d   = id_dst;
         op_a_d  = op_a_cap;
         op_b_d  = op_b_cap;
         imm_d   = id_imm_ext;
         ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
      end
   end

   // EX pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         dst_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         imm_q   <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         dst_q   <= dst_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ex_valid    = valid_q;
   assign bus.ex_rs       = rs_q;
   assign bus.ex_rt       = rt_q;
   assign bus.ex_dst      = dst_q;
   assign bus.ex_op_a     = op_a_q;
   assign bus.ex_op_b     = op_b_q;
   assign bus.ex_imm      = imm_q;
   assign bus.ex_ctrl     = ctrl_q;
   assign bus.stall_if_id = stall_if_id;
   assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; honours ID_EX_WB_BYPASS_EN.
module tb_id_ex_stage;
   import mips_pipe_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;
   int   exp_cnt;

   id_ex_stage_if bus_if ();

   id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, JAL, ALUOp}
   localparam logic [CTRL_W-1:0] C_RTYPE = {7'b1000010, ALU_ADD};
   localparam logic [CTRL_W-1:0] C_JAL   = {7'b1000011, ALU_ADD};
   localparam logic [CTRL_W-1:0] C_ADDI  = {7'b1000100, ALU_ADD};
   localparam logic [CTRL_W-1:0] C_LW    = {7'b1101100, ALU_ADD};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [15:0] imm, input logic [CTRL_W-1:0] ctrl);
      bus_if.id_valid      = v;
      bus_if.id_rs         = rs;
      bus_if.id_rt         = rt;
      bus_if.id_rd         = rd;
      bus_if.id_read_data1 = d1;
      bus_if.id_read_data2 = d2;
      bus_if.id_imm16      = imm;
      bus_if.id_ctrl       = ctrl;
   endtask

   initial begin
      n_vec   = 0;
      n_miss  = 0;
      exp_cnt = 0;
      rst_n   = 1'b0;
      bus_if.wb_reg_write = 1'b0;
      bus_if.wb_jal       = 1'b0;
      bus_if.wb_dst_reg   = '0;
      bus_if.wb_data      = '0;
      bus_if.ex_flush     = 1'b0;
      bus_if.ex_stall     = 1'b0;
      set_id(1'b1, 5'd3, 5'd5, 5'd7, 64'h1, 64'h2, 16'h1234, C_LW);

      // Reset
      tick();
      tick();
      chk("rst_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("rst_ctrl", 64'(bus_if.ex_ctrl), 64'd0);
      chk("rst_dst", 64'(bus_if.ex_dst), 64'd0);
      chk("rst_op_a", bus_if.ex_op_a, 64'd0);
      chk("rst_cnt", 64'(bus_if.bubble_cnt), 64'd0);
      chk("rst_stall", 64'(bus_if.stall_if_id), 64'd0);

      // Basic capture, RegDst, sign extension, upper word zeroed
      rst_n = 1'b1;
      set_id(1'b1, 5'd3, 5'd4, 5'd7, 64'hDEAD_BEEF_1234_5678, 64'hCAFE_0000_8765_4321,
             16'hFFF0, C_RTYPE);
      tick();
      chk("cap_valid", 64'(bus_if.ex_valid), 64'd1);
      chk("cap_dst", 64'(bus_if.ex_dst), 64'd7);
      chk("cap_imm", bus_if.ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("cap_op_a", bus_if.ex_op_a, 64'h0000_0000_1234_5678);
      chk("cap_op_b", bus_if.ex_op_b, 64'h0000_0000_8765_4321);
      chk("cap_rs", 64'(bus_if.ex_rs), 64'd3);
      chk("cap_rt", 64'(bus_if.ex_rt), 64'd4);
      chk("cap_ctrl", 64'(bus_if.ex_ctrl), 64'(C_RTYPE));

      set_id(1'b1, 5'd2, 5'd6, 5'd9, 64'h10, 64'h20, 16'h0040, C_JAL);
      tick();
      chk("jal_dst", 64'(bus_if.ex_dst), 64'd31);
      chk("jal_imm", bus_if.ex_imm, 64'h40);

      set_id(1'b1, 5'd2, 5'd6, 5'd9, 64'h10, 64'h20, 16'h7FFF, C_ADDI);
      tick();
      chk("itype_dst", 64'(bus_if.ex_dst), 64'd6);
      chk("itype_imm", bus_if.ex_imm, 64'h7FFF);

      set_id(1'b0, 5'd2, 5'd6, 5'd9, 64'h10, 64'h20, 16'h0001, C_RTYPE);
      tick();
      chk("inval_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("inval_ctrl", 64'(bus_if.ex_ctrl), 64'd0);

      // Load-use on rs: one stall cycle, one bubble
      set_id(1'b1, 5'd1, 5'd5, 5'd0, 64'h0, 64'h0, 16'h0, C_LW);
      tick();
      chk("lw_dst", 64'(bus_if.ex_dst), 64'd5);
      chk("lw_ctrl", 64'(bus_if.ex_ctrl), 64'(C_LW));
      set_id(1'b1, 5'd5, 5'd6, 5'd8, 64'h0, 64'h0, 16'h0, C_RTYPE);
      #1;
      chk("lu_rs_stall", 64'(bus_if.stall_if_id), 64'd1);
      tick();
      exp_cnt++;
      chk("lu_rs_bub_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("lu_rs_bub_ctrl", 64'(bus_if.ex_ctrl), 64'd0);
      chk("lu_rs_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));
      chk("lu_rs_stall_end", 64'(bus_if.stall_if_id), 64'd0);
      tick();
      chk("lu_rs_cons_valid", 64'(bus_if.ex_valid), 64'd1);
      chk("lu_rs_cons_dst", 64'(bus_if.ex_dst), 64'd8);
      chk("lu_rs_cons_rs", 64'(bus_if.ex_rs), 64'd5);

      // Load-use on rt
      set_id(1'b1, 5'd2, 5'd9, 5'd0, 64'h0, 64'h0, 16'h0, C_LW);
      tick();
      set_id(1'b1, 5'd10, 5'd9, 5'd11, 64'h0, 64'h0, 16'h0, C_RTYPE);
      #1;
      chk("lu_rt_stall", 64'(bus_if.stall_if_id), 64'd1);
      tick();
      exp_cnt++;
      chk("lu_rt_bub_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("lu_rt_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));
      tick();
      chk("lu_rt_cons_dst", 64'(bus_if.ex_dst), 64'd11);

      // Load to r0 never stalls
      set_id(1'b1, 5'd1, 5'd0, 5'd0, 64'h0, 64'h0, 16'h0, C_LW);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd12, 64'h0, 64'h0, 16'h0, C_RTYPE);
      #1;
      chk("r0_stall", 64'(bus_if.stall_if_id), 64'd0);
      tick();
      chk("r0_valid", 64'(bus_if.ex_valid), 64'd1);
      chk("r0_dst", 64'(bus_if.ex_dst), 64'd12);
      chk("r0_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));

      // Flush together with a load-use hazard
      set_id(1'b1, 5'd1, 5'd5, 5'd0, 64'h0, 64'h0, 16'h0, C_LW);
      tick();
      set_id(1'b1, 5'd5, 5'd6, 5'd8, 64'h0, 64'h0, 16'h0, C_RTYPE);
      bus_if.ex_flush = 1'b1;
      #1;
      chk("fl_stall", 64'(bus_if.stall_if_id), 64'd0);
      tick();
      bus_if.ex_flush = 1'b0;
      chk("fl_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("fl_ctrl", 64'(bus_if.ex_ctrl), 64'd0);
      chk("fl_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));
      #1;
      chk("fl_after_stall", 64'(bus_if.stall_if_id), 64'd0);
      tick();
      chk("fl_next_dst", 64'(bus_if.ex_dst), 64'd8);

      // Downstream stall freezes EX for three cycles
      set_id(1'b1, 5'd3, 5'd4, 5'd13, 64'h0000_0000_AAAA_0001, 64'h0, 16'h0, C_RTYPE);
      tick();
      chk("st_pre_dst", 64'(bus_if.ex_dst), 64'd13);
      bus_if.ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'(20 + i), 5'(21 + i), 5'(14 + i), 64'(i + 64'h77), 64'h0,
                16'(i), C_LW);
         tick();
         chk("st_hold_dst", 64'(bus_if.ex_dst), 64'd13);
         chk("st_hold_op_a", bus_if.ex_op_a, 64'h0000_0000_AAAA_0001);
         chk("st_hold_ctrl", 64'(bus_if.ex_ctrl), 64'(C_RTYPE));
      end
      bus_if.ex_stall = 1'b0;
      set_id(1'b1, 5'd7, 5'd8, 5'd17, 64'h0BBB, 64'h0, 16'h0, C_RTYPE);
      tick();
      chk("st_post_dst", 64'(bus_if.ex_dst), 64'd17);
      chk("st_post_op_a", bus_if.ex_op_a, 64'h0BBB);

      // Downstream stall coinciding with a hazard
      set_id(1'b1, 5'd1, 5'd12, 5'd0, 64'h0, 64'h0, 16'h0, C_LW);
      tick();
      set_id(1'b1, 5'd12, 5'd2, 5'd18, 64'h0, 64'h0, 16'h0, C_RTYPE);
      bus_if.ex_stall = 1'b1;
      #1;
      chk("sthz_stall", 64'(bus_if.stall_if_id), 64'd0);
      tick();
      chk("sthz_hold_dst", 64'(bus_if.ex_dst), 64'd12);
      chk("sthz_hold_ctrl", 64'(bus_if.ex_ctrl), 64'(C_LW));
      chk("sthz_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));
      bus_if.ex_stall = 1'b0;
      #1;
      chk("sthz_reeval", 64'(bus_if.stall_if_id), 64'd1);
      tick();
      exp_cnt++;
      chk("sthz_bub_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("sthz_bub_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));
      tick();
      chk("sthz_cons_dst", 64'(bus_if.ex_dst), 64'd18);

      // Writeback bypass
      bus_if.wb_reg_write = 1'b1;
      bus_if.wb_jal       = 1'b1;
      bus_if.wb_dst_reg   = 5'd3;
      bus_if.wb_data      = 64'hFFFF_FFFF_0000_1234;
      set_id(1'b1, 5'd2, 5'd31, 5'd19, 64'h1111, 64'h5555, 16'h0, C_RTYPE);
      tick();
`ifdef ID_EX_WB_BYPASS_EN
      chk("byp_jal_op_b", bus_if.ex_op_b, 64'h1234);
`else
      chk("byp_jal_op_b", bus_if.ex_op_b, 64'h5555);
`endif
      chk("byp_jal_op_a", bus_if.ex_op_a, 64'h1111);

      bus_if.wb_jal = 1'b0;
      set_id(1'b1, 5'd3, 5'd31, 5'd19, 64'h1111, 64'h5555, 16'h0, C_RTYPE);
      tick();
`ifdef ID_EX_WB_BYPASS_EN
      chk("byp_rs_op_a", bus_if.ex_op_a, 64'h1234);
`else
      chk("byp_rs_op_a", bus_if.ex_op_a, 64'h1111);
`endif
      chk("byp_rs_op_b", bus_if.ex_op_b, 64'h5555);

      bus_if.wb_dst_reg = 5'd0;
      set_id(1'b1, 5'd0, 5'd0, 5'd19, 64'h2222, 64'h3333, 16'h0, C_RTYPE);
      tick();
      chk("byp_r0_op_a", bus_if.ex_op_a, 64'h2222);
      chk("byp_r0_op_b", bus_if.ex_op_b, 64'h3333);

      bus_if.wb_reg_write = 1'b0;
      bus_if.wb_jal       = 1'b1;
      set_id(1'b1, 5'd2, 5'd31, 5'd19, 64'h1111, 64'h5555, 16'h0, C_RTYPE);
      tick();
      chk("byp_nowr_op_b", bus_if.ex_op_b, 64'h5555);
      bus_if.wb_jal = 1'b0;

      // Reset during a load-use stall
      set_id(1'b1, 5'd1, 5'd5, 5'd0, 64'h0, 64'h0, 16'h0, C_LW);
      tick();
      set_id(1'b1, 5'd5, 5'd6, 5'd8, 64'h0, 64'h0, 16'h0, C_RTYPE);
      #1;
      chk("rstst_stall_pre", 64'(bus_if.stall_if_id), 64'd1);
      rst_n = 1'b0;
      tick();
      exp_cnt = 0;
      chk("rstst_valid", 64'(bus_if.ex_valid), 64'd0);
      chk("rstst_stall", 64'(bus_if.stall_if_id), 64'd0);
      chk("rstst_cnt", 64'(bus_if.bubble_cnt), 64'(exp_cnt));
      chk("rstst_ctrl", 64'(bus_if.ex_ctrl), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("rstst_resume_dst", 64'(bus_if.ex_dst), 64'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS pipeline, directly downstream of the register file and decode logic. Each cycle it registers the two register-file read operands, the sign-extended immediate, the decoded control bundle and the destination register into the EX stage. It also detects load-use hazards: it stalls IF/ID and inserts a bubble into EX. It honours branch flushes and downstream stalls, and counts inserted bubbles.

## Interface
- DATA_W, 64, operand width; upper 32 bits are always zero, as in the register file.
- REG_AW, 5, register index width.
- CNT_W, 16, bubble counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_AW  decoded register fields; id_rs and id_rt also drive the register file read addresses.
- id_read_data1, id_read_data2  in  DATA_W  register file outputs for id_rs and id_rt; these are stable before the rising edge.
- id_imm16  in  16  raw immediate.
- id_ctrl  in  CTRL_W  decoded control bundle; the field layout is defined in the package.
- wb_reg_write, wb_jal  in  1  writeback write enable, and writeback jump-and-link (which forces destination 31).
- wb_dst_reg  in  REG_AW; wb_data  in  DATA_W  writeback destination and data.
- ex_flush  in  1  taken branch/jump; kills the instruction entering EX.
- ex_stall  in  1  downstream hold request.
- ex_valid  out  1; ex_rs, ex_rt, ex_dst  out  REG_AW; ex_op_a, ex_op_b, ex_imm  out  DATA_W; ex_ctrl  out  CTRL_W.
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational).
- bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles.

## Operation
- Control bundle fields: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, JmpandLink, ALUOp[3:0]. CTRL_W = 11.
- Destination register:
  - 31 if JmpandLink.
  - Otherwise id_rd if RegDst.
  - Otherwise id_rt.
- ex_imm is id_imm16 sign-extended to DATA_W.
- ex_op_a and ex_op_b capture id_read_data1 and id_read_data2 with bits [63:32] forced to 0.
- Load-use hazard, hz: all of the following hold:
  - ex_valid is 1;
  - ex_ctrl.MemRead is 1;
  - ex_dst is not 0;
  - id_valid is 1;
  - ex_dst equals id_rs, or ex_dst equals id_rt.
- stall_if_id = hz && !ex_flush && !ex_stall.
- Per-edge priority, highest first:
  1. !rst_n: all outputs are cleared to 0, including bubble_cnt.
  2. ex_flush: ex_valid is cleared to 0 and ex_ctrl to 0; other fields don't care.
  3. ex_stall: all EX registers hold.
  4. hz: bubble. ex_valid is cleared to 0 and ex_ctrl to 0. bubble_cnt increments, saturating at all-ones.
  5. Otherwise: capture all fields; ex_valid is set to id_valid. If id_valid is 0, ex_ctrl is cleared to 0.
- A bubble never carries RegWrite or MemWrite, so no false side effects occur.
- Register 0 as a destination never triggers hz.

## Timing
- Latency is one cycle: decode values at edge N appear on the ex_* outputs after edge N.
- stall_if_id is valid in the same cycle as the hazard. After one bubble, ex_ctrl.MemRead is 0, so hz clears. A load-use stall therefore lasts exactly one cycle.
- ex_flush and hz in the same cycle: flush wins. No bubble is counted and stall_if_id is 0.
- ex_stall and hz in the same cycle: EX holds, stall_if_id is 0, and the upstream stall is owned by the stall source. The hazard is re-evaluated on the next cycle.
- Reset asserted mid-stall: the next cycle starts clean, with ex_valid 0 and stall_if_id 0.

## Configuration
- ID_EX_WB_BYPASS_EN defined: write-through bypass on capture.
  - The effective write register is 31 if wb_jal, otherwise wb_dst_reg.
  - If wb_reg_write is 1, the effective write register is not 0, and it equals id_rs (or id_rt), then ex_op_a (or ex_op_b) captures {32'b0, wb_data[31:0]} instead of the register file value.
- Undefined: the wb_* ports are ignored and operands come only from the register file.

## Structure
- Package mips_pipe_pkg holds:
  - CTRL_W and the control field bit indices;
  - REG_RA = 31 and REG_ZERO = 0;
  - the ALUOp encodings shared with EX.
- Sub-module hazard_detect_unit: purely combinational hz and stall_if_id logic, instantiated once. The pipeline registers, bypass muxes and counter stay in id_ex_stage.

## Test plan
- Reset, then release with id_valid 1, id_rs 3, id_rt 4, id_imm16 16'hFFF0, RegDst 1, id_rd 7 -> after one edge: ex_valid 1, ex_dst 7, ex_imm 64'hFFFF_FFFF_FFFF_FFF0, ex_op_a[63:32] 0.
- Load into rt 5 (MemRead 1), then a consumer with id_rs 5 -> stall_if_id 1 for exactly one cycle, one bubble (ex_valid 0, ex_ctrl 0), bubble_cnt 1, then the consumer enters EX.
- Load to register 0 followed by a consumer of register 0 -> no stall, bubble_cnt unchanged.
- ex_flush asserted together with a load-use hazard -> ex_valid 0, stall_if_id 0, bubble_cnt unchanged.
- ex_stall held for 3 cycles with changing decode inputs -> ex_* outputs frozen; the first post-stall edge captures the current decode inputs.
- With ID_EX_WB_BYPASS_EN: wb_jal 1, wb_data 0x1234, id_rt 31 -> ex_op_b 0x1234. Without the macro -> ex_op_b equals id_read_data2.
